// File: rtl/tpu_sched_pkg.sv
// Shared types and widths for the TPU job scheduler: FSM state encoding,
// requester-id width, tile-count and SRAM base-address widths.
package tpu_sched_pkg;

  localparam int NUM_REQ    = 4;
  localparam int TILE_BITS  = 8;
  localparam int BASE_WIDTH = 10;
  localparam int REQ_ID_W   = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  // Round-robin successor of a requester id.
  function automatic logic [REQ_ID_W-1:0] next_id(input logic [REQ_ID_W-1:0] id);
    return REQ_ID_W'((int'(id) + 1) % NUM_REQ);
  endfunction

endpackage

// File: rtl/tpu_job_scheduler_if.sv
// Host-queue and array-controller signal bundle for tpu_job_scheduler.
// master = host/array side, slave = scheduler.
interface tpu_job_scheduler_if import tpu_sched_pkg::*; ();

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*TILE_BITS-1:0]  req_tiles;
  logic [NUM_REQ*BASE_WIDTH-1:0] req_base;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          tpu_start;
  logic [BASE_WIDTH-1:0]         tile_base;
  logic                          tpu_done;
  logic [NUM_REQ-1:0]            job_done;
  logic [REQ_ID_W-1:0]           grant_id;
  logic                          busy;
  logic                          err;

  modport master (
    output req_valid, req_tiles, req_base, tpu_done,
    input  req_ready, tpu_start, tile_base, job_done, grant_id, busy, err
  );

  modport slave (
    input  req_valid, req_tiles, req_base, tpu_done,
    output req_ready, tpu_start, tile_base, job_done, grant_id, busy, err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// above ptr (wrapping), returning a one-hot grant and its encoded id.
module rr_arbiter import tpu_sched_pkg::*; (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [REQ_ID_W-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [REQ_ID_W-1:0] grant_id
);

  logic found;
  int   idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave a value unassigned and infer a latch.
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = REQ_ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/tpu_job_scheduler.sv
// Round-robin multi-tile job sequencer in front of one systolic-array controller.
// Optional watchdog: define TPU_SCHED_WATCHDOG_EN to abort stalled tiles after TIMEOUT_CYCLES.
module tpu_job_scheduler import tpu_sched_pkg::*; #(
  parameter int TILE_STRIDE = 128
`ifdef TPU_SCHED_WATCHDOG_EN
  ,
  parameter int TIMEOUT_CYCLES = 1023
`endif
) (
  input logic                clk,
  input logic                srstn,
  tpu_job_scheduler_if.slave bus
);

  state_t                state, state_nx;
  logic [REQ_ID_W-1:0]   rr_ptr, rr_ptr_nx;
  logic [REQ_ID_W-1:0]   grant_id_q, grant_id_nx;
  logic [TILE_BITS-1:0]  tiles_left, tiles_left_nx;
  logic [BASE_WIDTH-1:0] tile_base_q, tile_base_nx;
  logic                  start_q, start_nx;
  logic [NUM_REQ-1:0]    done_q, done_nx;
  logic                  busy_q, busy_nx;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [REQ_ID_W-1:0]   arb_id;
  logic                  transfer;
  logic [TILE_BITS-1:0]  win_tiles;
  logic                  wd_fire;

  rr_arbiter u_arb (
    .req      (bus.req_valid),
    .ptr      (rr_ptr),
    .grant    (arb_grant),
    .grant_id (arb_id)
  );

  assign bus.req_ready = (state == IDLE) ? arb_grant : '0;
  assign transfer      = |(bus.req_valid & bus.req_ready);
  assign win_tiles     = bus.req_tiles[int'(arb_id)*TILE_BITS +: TILE_BITS];

`ifdef TPU_SCHED_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  // The counter restarts with every tile; a late done on the final count wins.
  assign wd_fire = (state == WAIT) && !bus.tpu_done &&
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == ISSUE)     wd_cnt <= '0;
      else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
      if (wd_fire)            err_q  <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign wd_fire = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    state_nx      = state;
    rr_ptr_nx     = rr_ptr;
    grant_id_nx   = grant_id_q;
    tiles_left_nx = tiles_left;
    tile_base_nx  = tile_base_q;
    start_nx      = 1'b0;
    done_nx       = '0;
    busy_nx       = busy_q;
    unique case (state)
      IDLE: begin
        if (transfer) begin
          state_nx      = ISSUE;
          rr_ptr_nx     = next_id(arb_id);
          grant_id_nx   = arb_id;
          tiles_left_nx = (win_tiles == '0) ? TILE_BITS'(1) : win_tiles;
          tile_base_nx  = bus.req_base[int'(arb_id)*BASE_WIDTH +: BASE_WIDTH];
          start_nx      = 1'b1;
          busy_nx       = 1'b1;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (bus.tpu_done) begin
          if (tiles_left > TILE_BITS'(1)) begin
            state_nx      = ISSUE;
            tiles_left_nx = tiles_left - 1'b1;
            tile_base_nx  = tile_base_q + BASE_WIDTH'(TILE_STRIDE);
            start_nx      = 1'b1;
          end else begin
            state_nx            = DONE;
            done_nx[grant_id_q] = 1'b1;
          end
        end else if (wd_fire) begin
          state_nx            = DONE;
          done_nx[grant_id_q] = 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id_q  <= '0;
      tiles_left  <= '0;
      tile_base_q <= '0;
      start_q     <= 1'b0;
      done_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nx;
      rr_ptr      <= rr_ptr_nx;
      grant_id_q  <= grant_id_nx;
      tiles_left  <= tiles_left_nx;
      tile_base_q <= tile_base_nx;
      start_q     <= start_nx;
      done_q      <= done_nx;
      busy_q      <= busy_nx;
    end
  end

  assign bus.tpu_start = start_q;
  assign bus.tile_base = tile_base_q;
  assign bus.job_done  = done_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_tpu_job_scheduler.sv
// Self-checking bench for tpu_job_scheduler: directed scenarios plus randomized
// job streams scored against a pending-set / round-robin reference model.
module tb_tpu_job_scheduler;
  import tpu_sched_pkg::*;

  localparam int STRIDE = 128;

  logic clk   = 1'b0;
  logic srstn = 1'b0;

  tpu_job_scheduler_if bus();

`ifdef TPU_SCHED_WATCHDOG_EN
  tpu_job_scheduler #(.TILE_STRIDE(STRIDE), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .srstn(srstn), .bus(bus));
`else
  tpu_job_scheduler #(.TILE_STRIDE(STRIDE)) dut (
    .clk(clk), .srstn(srstn), .bus(bus));
`endif

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: set of pending requests, their held payloads, and the
  // round-robin starting point.
  logic [NUM_REQ-1:0] pend;
  int                 tiles_m [NUM_REQ];
  int                 base_m  [NUM_REQ];
  int                 ptr_m;
  int                 order   [5];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    bus.req_valid = pend;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_tiles[i*TILE_BITS +: TILE_BITS]   = TILE_BITS'(tiles_m[i]);
      bus.req_base[i*BASE_WIDTH +: BASE_WIDTH] = BASE_WIDTH'(base_m[i]);
    end
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] m, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (m[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Serves one job end to end as the array controller would.
  task automatic run_job(input int max_delay, input bit spur_issue, input bit hold);
    int id, n, b, d;
    drive();
    #1;
    id = pick(pend, ptr_m);
    n  = (tiles_m[id] == 0) ? 1 : tiles_m[id];
    b  = base_m[id];
    check("req_ready_grant", 32'(bus.req_ready), 32'(1 << id));
    tick();
    ptr_m = (id + 1) % NUM_REQ;
    if (!hold) pend[id] = 1'b0;
    drive();
    for (int t = 0; t < n; t++) begin
      check("tpu_start_issue", 32'(bus.tpu_start), 32'd1);
      check("tile_base", 32'(bus.tile_base), 32'((b + t * STRIDE) % (1 << BASE_WIDTH)));
      check("grant_id", 32'(bus.grant_id), 32'(id));
      check("busy_in_job", 32'(bus.busy), 32'd1);
      check("req_ready_busy", 32'(bus.req_ready), 32'd0);
      if (spur_issue) bus.tpu_done = 1'b1;
      tick();
      bus.tpu_done = 1'b0;
      check("tpu_start_pulse_len", 32'(bus.tpu_start), 32'd0);
      d = $urandom_range(max_delay, 0);
      repeat (d) tick();
      bus.tpu_done = 1'b1;
      tick();
      bus.tpu_done = 1'b0;
      if (t < n - 1) check("job_done_early", 32'(bus.job_done), 32'd0);
    end
    check("job_done_pulse", 32'(bus.job_done), 32'(1 << id));
    check("busy_during_done", 32'(bus.busy), 32'd1);
    check("tpu_start_after_last", 32'(bus.tpu_start), 32'd0);
    check("err_clear", 32'(bus.err), 32'd0);
    tick();
    check("job_done_cleared", 32'(bus.job_done), 32'd0);
    check("busy_fall", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    #2 srstn = 1'b0;
    #1;
    check("rst_tpu_start", 32'(bus.tpu_start), 32'd0);
    check("rst_tile_base", 32'(bus.tile_base), 32'd0);
    check("rst_job_done", 32'(bus.job_done), 32'd0);
    check("rst_grant_id", 32'(bus.grant_id), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    repeat (2) begin
      tick();
      check("rst_hold_job_done", 32'(bus.job_done), 32'd0);
    end
    #2 srstn = 1'b1;
    ptr_m = 0;
    tick();
  endtask

  initial begin
    pend = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      tiles_m[i] = 1;
      base_m[i]  = 0;
    end
    bus.tpu_done = 1'b0;
    drive();
    ptr_m = 0;
    do_reset();
    check("idle_ready_none", 32'(bus.req_ready), 32'd0);

    // Single job: requester 2, three tiles from base 5.
    pend       = 4'b0100;
    tiles_m[2] = 3;
    base_m[2]  = 5;
    run_job(3, 1'b0, 1'b0);

    // Fairness from a fresh pointer: all four held, one tile each.
    do_reset();
    pend = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) tiles_m[i] = 1;
    order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      drive();
      #1;
      check("fair_order", 32'(bus.req_ready), 32'(1 << order[k]));
      run_job(1, 1'b0, 1'b1);
    end

    // Zero tiles behaves as one tile, starting at the wrapping end of the map.
    pend       = 4'b0010;
    tiles_m[1] = 0;
    base_m[1]  = 1000;
    run_job(2, 1'b0, 1'b0);

    // Spurious done in IDLE, then in every ISSUE cycle of a two-tile job.
    pend = '0;
    drive();
    bus.tpu_done = 1'b1;
    tick();
    bus.tpu_done = 1'b0;
    check("spur_idle_busy", 32'(bus.busy), 32'd0);
    check("spur_idle_start", 32'(bus.tpu_start), 32'd0);
    pend       = 4'b1000;
    tiles_m[3] = 2;
    base_m[3]  = 960;
    run_job(2, 1'b1, 1'b0);

    // Randomized stream: new requests arrive between jobs and must all be served.
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && ($urandom_range(2, 0) == 0)) begin
          pend[i]    = 1'b1;
          tiles_m[i] = $urandom_range(4, 0);
          base_m[i]  = $urandom_range((1 << BASE_WIDTH) - 1, 0);
        end
      end
      if (pend == '0) begin
        pend[0]    = 1'b1;
        tiles_m[0] = $urandom_range(4, 1);
        base_m[0]  = $urandom_range((1 << BASE_WIDTH) - 1, 0);
      end
      run_job(3, 1'($urandom_range(1, 0)), 1'b0);
    end
    while (pend != '0) run_job(2, 1'b0, 1'b0);

    // Reset mid-WAIT: outputs clear at once, no completion, pointer restarts at 0.
    pend       = 4'b0010;
    tiles_m[1] = 3;
    base_m[1]  = 64;
    drive();
    tick();
    pend = '0;
    drive();
    tick();
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    do_reset();
    pend       = 4'b1001;
    tiles_m[0] = 2;
    base_m[0]  = 12;
    tiles_m[3] = 1;
    base_m[3]  = 300;
    run_job(2, 1'b0, 1'b0);
    run_job(2, 1'b0, 1'b0);

`ifdef TPU_SCHED_WATCHDOG_EN
    // Watchdog: no tpu_done, abort after 16 WAIT cycles with a sticky err.
    pend       = 4'b0100;
    tiles_m[2] = 2;
    base_m[2]  = 7;
    drive();
    tick();
    pend = '0;
    drive();
    check("wd_start", 32'(bus.tpu_start), 32'd1);
    tick();
    for (int k = 1; k < 16; k++) begin
      check("wd_no_done_yet", 32'(bus.job_done), 32'd0);
      tick();
    end
    check("wd_err_before", 32'(bus.err), 32'd0);
    tick();
    check("wd_job_done", 32'(bus.job_done), 32'b0100);
    check("wd_err_set", 32'(bus.err), 32'd1);
    tick();
    check("wd_job_done_clear", 32'(bus.job_done), 32'd0);
    check("wd_busy_fall", 32'(bus.busy), 32'd0);
    repeat (5) tick();
    check("wd_err_sticky", 32'(bus.err), 32'd1);
    do_reset();
`else
    // Without the watchdog a missing tpu_done stalls the job indefinitely.
    pend       = 4'b0100;
    tiles_m[2] = 1;
    base_m[2]  = 7;
    drive();
    tick();
    pend = '0;
    drive();
    tick();
    repeat (40) tick();
    check("stall_busy", 32'(bus.busy), 32'd1);
    check("stall_job_done", 32'(bus.job_done), 32'd0);
    check("stall_err", 32'(bus.err), 32'd0);
    bus.tpu_done = 1'b1;
    tick();
    bus.tpu_done = 1'b0;
    check("stall_release_done", 32'(bus.job_done), 32'b0100);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tpu_job_scheduler.md
# tpu_job_scheduler

Shares one systolic-array controller between `NUM_REQ` requesters and sequences multi-tile jobs on it. It accepts one job at a time from a round-robin-selected requester, pulses `tpu_start` once per tile, and waits for `tpu_done` before issuing the next tile. For each tile it supplies the SRAM base address and it reports job completion per requester. It sits between the host-side job queues and the array controller's `tpu_start`/`tpu_done` pair.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `TILE_BITS`, 8: width of per-job tile count.
- `BASE_WIDTH`, 10: SRAM base address width.
- `TILE_STRIDE`, 128: address increment between consecutive tiles.
- `TIMEOUT_CYCLES`, 1023: watchdog limit, used only with the watchdog macro.
- `clk`  in  1  clock.
- `srstn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  job request per requester; held until accepted.
- `req_tiles`  in  NUM_REQ*TILE_BITS  tile count per requester, slice i = requester i.
- `req_base`  in  NUM_REQ*BASE_WIDTH  first-tile base address per requester.
- `req_ready`  out  NUM_REQ  one-hot combinational grant; transfer = valid & ready.
- `tpu_start`  out  1  registered one-cycle start pulse to the array controller.
- `tile_base`  out  BASE_WIDTH  registered base address of the current tile.
- `tpu_done`  in  1  one-cycle done pulse from the array controller.
- `job_done`  out  NUM_REQ  registered one-hot completion pulse.
- `grant_id`  out  $clog2(NUM_REQ)  requester owning the array; valid while `busy`.
- `busy`  out  1  high from acceptance until `job_done`.
- `err`  out  1  sticky watchdog flag.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - `req_ready` = one-hot round-robin winner among `req_valid`, searching upward from `rr_ptr`.
  - On transfer, capture `req_tiles` (0 treated as 1), `req_base` and the winner id; set `rr_ptr` = winner+1 mod NUM_REQ; go to ISSUE.
- ISSUE: `tpu_start` = 1 for exactly one cycle; go to WAIT.
- WAIT:
  - On `tpu_done` with tiles_left > 1: decrement tiles_left, set `tile_base` += TILE_STRIDE (wraps mod 2^BASE_WIDTH), go to ISSUE.
  - On `tpu_done` with tiles_left == 1: go to DONE.
- DONE: pulse `job_done[grant_id]` for one cycle; go to IDLE.
- `req_ready` is 0 in every state except IDLE.
- `tpu_done` is ignored outside WAIT, including a spurious pulse in IDLE or ISSUE.
- `rr_ptr` changes only on a transfer. Requests that are not granted wait and are never dropped.

## Timing
- Reset (asynchronous, immediate): state IDLE, `rr_ptr` 0, `tpu_start` 0, `tile_base` 0, `job_done` 0, `grant_id` 0, `busy` 0, `err` 0. This applies mid-job too; no completion pulse is emitted.
- Transfer at edge E0 → `tpu_start` high in cycle E0+1.
- `tpu_done` sampled at edge Ek → next `tpu_start` in cycle Ek+1, with `tile_base` already updated.
- Last `tpu_done` at edge Ek → `job_done` high in cycle Ek+1. IDLE in Ek+2, and the next transfer can occur at edge Ek+2.
- `busy` rises in the cycle after the transfer and falls in the cycle after `job_done`.
- Simultaneous requests: exactly one grant per IDLE cycle.

## Configuration
- `TPU_SCHED_WATCHDOG_EN` defined:
  - A cycle counter runs in WAIT and clears on each ISSUE.
  - Reaching TIMEOUT_CYCLES sets `err` (sticky until reset), forces DONE and emits `job_done` for the aborted job.
- Undefined: no counter; `err` is tied 0; WAIT lasts indefinitely.

## Structure
- Package `tpu_sched_pkg`: state enum, `REQ_ID_W = $clog2(NUM_REQ)`, and the tile-count/base widths as localparams.
- One sub-module, `rr_arbiter`. Inputs: request vector and pointer. Output: one-hot grant plus encoded id. Purely combinational; `rr_ptr` is held in the parent.

## Test plan
- Single job: req_valid[2]=1, tiles=3, base=5 → three `tpu_start` pulses with tile_base 5, 133, 261; `job_done`=4'b0100 one cycle after the 3rd `tpu_done`.
- Fairness: all four requesters hold valid with tiles=1 → grants in order 0,1,2,3,0; no requester starves.
- Zero tiles: tiles=0 → exactly one `tpu_start`, then `job_done`.
- Spurious done: `tpu_done` in IDLE and in the ISSUE cycle → ignored; the job still needs the full tile count of dones.
- Reset mid-WAIT: deassert srstn → all outputs 0 immediately, no `job_done`; a new request after release is served normally.
- Watchdog (macro on, TIMEOUT_CYCLES=16): no `tpu_done` → `err`=1 and `job_done` pulse 16 cycles into WAIT; `err` stays 1 until reset.
